// File: rtl/intc_dispatcher.sv
// Priority interrupt dispatcher: latches rising edges of the peripheral
// interrupt lines, gates them with per-source enables, picks the most urgent
// source (round-robin among equal priorities) and presents it to the
// processor until it is acknowledged or the service timeout expires.
module intc_dispatcher #(
    parameter int NO_OF_PERIPHERALS = 16,
    parameter int WIDTH             = $clog2(NO_OF_PERIPHERALS),
    parameter int TIMEOUT_CYCLES    = 256
) (
    input  logic                         pclk_i,
    input  logic                         prst_i,
    input  logic [WIDTH:0]               paddr_i,
    input  logic [WIDTH-1:0]             pwdata_i,
    input  logic                         pwrite_en_i,
    input  logic                         pvalid_i,
    output logic [WIDTH-1:0]             prdata_o,
    output logic                         pready_o,
    input  logic [NO_OF_PERIPHERALS-1:0] interrupt_active_i,
    input  logic                         interrupt_serviced_i,
    output logic [WIDTH-1:0]             interrupt_to_be_serviced_o,
    output logic                         interrupt_valid_o,
    output logic                         timeout_o,
    output logic [NO_OF_PERIPHERALS-1:0] pending_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_ARB   = 3'b010,
        ST_GRANT = 3'b100
    } state_t;

    state_t                         state_r, state_s;
    logic [WIDTH-1:0]               prio_r [NO_OF_PERIPHERALS];
    logic [NO_OF_PERIPHERALS-1:0]   enable_r;
    logic [NO_OF_PERIPHERALS-1:0]   prev_r;
    logic [NO_OF_PERIPHERALS-1:0]   pending_r;
    logic [WIDTH-1:0]               prdata_r;
    logic                           pready_r;
    logic [WIDTH-1:0]               last_grant_r, last_grant_s;
    logic [WIDTH-1:0]               grant_id_r, grant_id_s;
    logic                           grant_valid_r, grant_valid_s;
    logic                           timeout_r, timeout_s;
    logic [CNT_W-1:0]               count_r, count_s;

    logic [NO_OF_PERIPHERALS-1:0]   set_s;
    logic [NO_OF_PERIPHERALS-1:0]   clear_s;
    logic [NO_OF_PERIPHERALS-1:0]   eligible_s;
    logic                           win_found_s;
    logic [WIDTH-1:0]               win_idx_s;
    logic [WIDTH-1:0]               win_pri_s;
    logic [WIDTH-1:0]               scan_idx_s;
    logic [WIDTH-1:0]               reg_idx_s;

    assign reg_idx_s  = paddr_i[WIDTH-1:0];
    assign set_s      = interrupt_active_i & ~prev_r;
    assign eligible_s = pending_r & enable_r;

    // Register file: priorities, enables and the single-cycle access handshake.
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            for (int i = 0; i < NO_OF_PERIPHERALS; i++) begin
                prio_r[i] <= {WIDTH{1'b0}};
            end
            enable_r <= {NO_OF_PERIPHERALS{1'b0}};
            prdata_r <= {WIDTH{1'b0}};
            pready_r <= 1'b0;
        end else if (pvalid_i) begin
            pready_r <= 1'b1;
            if (pwrite_en_i) begin
                if (paddr_i[WIDTH]) begin
                    enable_r[reg_idx_s] <= pwdata_i[0];
                end else begin
                    prio_r[reg_idx_s] <= pwdata_i;
                end
            end else begin
                if (paddr_i[WIDTH]) begin
                    prdata_r <= WIDTH'(enable_r[reg_idx_s]);
                end else begin
                    prdata_r <= prio_r[reg_idx_s];
                end
            end
        end else begin
            pready_r <= 1'b0;
        end
    end

    // Edge capture and pending bookkeeping; a new edge beats a same-cycle clear.
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            prev_r    <= {NO_OF_PERIPHERALS{1'b0}};
            pending_r <= {NO_OF_PERIPHERALS{1'b0}};
        end else begin
            prev_r    <= interrupt_active_i;
            pending_r <= (pending_r & ~clear_s) | set_s;
        end
    end

    // Winner search: scan from last_grant+1 with wrap, strict '>' keeps the
    // first source in scan order on a priority tie.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {WIDTH{1'b0}};
        win_pri_s   = {WIDTH{1'b0}};
        scan_idx_s  = {WIDTH{1'b0}};
        for (int k = 1; k <= NO_OF_PERIPHERALS; k++) begin
            scan_idx_s = last_grant_r + WIDTH'(k);
            if (eligible_s[scan_idx_s] && (!win_found_s || (prio_r[scan_idx_s] > win_pri_s))) begin
                win_found_s = 1'b1;
                win_idx_s   = scan_idx_s;
                win_pri_s   = prio_r[scan_idx_s];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Dispatcher next-state and next-output logic.
    always_comb begin
        state_s       = state_r;
        grant_id_s    = grant_id_r;
        grant_valid_s = grant_valid_r;
        timeout_s     = 1'b0;
        count_s       = count_r;
        last_grant_s  = last_grant_r;
        clear_s       = {NO_OF_PERIPHERALS{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (|eligible_s) begin
                    state_s = ST_ARB;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (win_found_s) begin
                    grant_id_s    = win_idx_s;
                    grant_valid_s = 1'b1;
                    count_s       = {CNT_W{1'b0}};
                    state_s       = ST_GRANT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (interrupt_serviced_i) begin
                    clear_s       = {{(NO_OF_PERIPHERALS-1){1'b0}}, 1'b1} << grant_id_r;
                    last_grant_s  = grant_id_r;
                    grant_valid_s = 1'b0;
                    grant_id_s    = {WIDTH{1'b0}};
                    state_s       = ST_IDLE;
                end else if (count_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    last_grant_s  = grant_id_r;
                    grant_valid_s = 1'b0;
                    grant_id_s    = {WIDTH{1'b0}};
                    timeout_s     = 1'b1;
                    state_s       = ST_IDLE;
                end else begin
                    count_s = count_r + CNT_W'(1);
                end
            end
            default: begin
                grant_valid_s = 1'b0;
                grant_id_s    = {WIDTH{1'b0}};
                state_s       = ST_IDLE;
            end
        endcase
    end

    // Dispatcher state and registered grant outputs.
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            state_r       <= ST_IDLE;
            grant_id_r    <= {WIDTH{1'b0}};
            grant_valid_r <= 1'b0;
            timeout_r     <= 1'b0;
            count_r       <= {CNT_W{1'b0}};
            last_grant_r  <= WIDTH'(NO_OF_PERIPHERALS - 1);
        end else begin
            state_r       <= state_s;
            grant_id_r    <= grant_id_s;
            grant_valid_r <= grant_valid_s;
            timeout_r     <= timeout_s;
            count_r       <= count_s;
            last_grant_r  <= last_grant_s;
        end
    end

    assign prdata_o                   = prdata_r;
    assign pready_o                   = pready_r;
    assign interrupt_to_be_serviced_o = grant_id_r;
    assign interrupt_valid_o          = grant_valid_r;
    assign timeout_o                  = timeout_r;
    assign pending_o                  = pending_r;

endmodule
